// File: rtl/multu_seq.sv
// ---------------------------------------------------------------------------
// multu_seq -- sequential 32x32 -> 64-bit shift-add multiplier for the ALU.
//
// A request with an accepted function code latches the operands, then
// performs one shift-add step per clock for 32 clocks and publishes the
// product on hi/lo with a one-cycle done pulse.
//
// Ports:
//   clk    in   1   clock, all state changes on the rising edge
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   one-cycle request, honoured only while idle
//   ctl    in   6   function code: 6'd25 MULTU, 6'd24 MULT (signed build only)
//   a      in  32   multiplicand
//   b      in  32   multiplier
//   busy   out  1   high while a multiply is running or completing
//   done   out  1   one-cycle completion pulse, coincident with new hi/lo
//   hi     out 32   upper product word (held until the next completion)
//   lo     out 32   lower product word (held until the next completion)
//
// Build option:
//   MULT_SIGNED_EN -- when defined, ctl=6'd24 runs a signed multiply by
//   multiplying magnitudes and negating the result when the operand signs
//   differ. When undefined, ctl=6'd24 is ignored like any other code.
// ---------------------------------------------------------------------------
module multu_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [5:0]  ctl,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] CTL_MULTU = 6'd25;
`ifdef MULT_SIGNED_EN
    localparam logic [5:0] CTL_MULT  = 6'd24;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] mcand_q;
    logic [31:0] mplr_q;
    logic [63:0] acc_q;
    logic [4:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        accept_d;
    logic [31:0] mcand_d;
    logic [31:0] mplr_d;
    logic [32:0] sum_d;
    logic [63:0] acc_d;
    logic [63:0] prod_d;

`ifdef MULT_SIGNED_EN
    logic        neg_q;
    logic        neg_d;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        if (v[31]) begin
            return (~v) + 32'd1;
        end else begin
            return v;
        end
    endfunction
`endif

    // Decode whether this cycle's request is accepted and what gets latched.
    always_comb begin
        accept_d = 1'b0;
        mcand_d  = a;
        mplr_d   = b;
`ifdef MULT_SIGNED_EN
        neg_d    = 1'b0;
`endif
        if ((state_q == ST_IDLE) && start) begin
            case (ctl)
                CTL_MULTU: begin
                    accept_d = 1'b1;
                end
`ifdef MULT_SIGNED_EN
                CTL_MULT: begin
                    accept_d = 1'b1;
                    mcand_d  = abs32(a);
                    mplr_d   = abs32(b);
                    neg_d    = a[31] ^ b[31];
                end
`endif
                default: begin
                    accept_d = 1'b0;
                end
            endcase
        end else begin
            accept_d = 1'b0;
        end
    end

    // One shift-add step: conditionally add the multiplicand into the upper
    // half with a carry bit, then shift carry/upper/lower right by one.
    always_comb begin
        sum_d = {1'b0, acc_q[63:32]};
        if (mplr_q[0]) begin
            sum_d = {1'b0, acc_q[63:32]} + {1'b0, mcand_q};
        end else begin
            sum_d = {1'b0, acc_q[63:32]};
        end
        acc_d = {sum_d, acc_q[31:1]};
    end

    // Final product as published on hi/lo.
    always_comb begin
        prod_d = acc_q;
`ifdef MULT_SIGNED_EN
        if (neg_q) begin
            prod_d = (~acc_q) + 64'd1;
        end else begin
            prod_d = acc_q;
        end
`endif
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mcand_q <= 32'd0;
            mplr_q  <= 32'd0;
            acc_q   <= 64'd0;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MULT_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (accept_d) begin
                        mcand_q <= mcand_d;
                        mplr_q  <= mplr_d;
                        acc_q   <= 64'd0;
                        cnt_q   <= 5'd0;
                        busy_q  <= 1'b1;
`ifdef MULT_SIGNED_EN
                        neg_q   <= neg_d;
`endif
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_q  <= acc_d;
                    mplr_q <= {1'b0, mplr_q[31:1]};
                    cnt_q  <= cnt_q + 5'd1;
                    busy_q <= 1'b1;
                    done_q <= 1'b0;
                    // The counter reads 31 while the 32nd step is applied.
                    if (cnt_q == 5'd31) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // Any start seen here is dropped: only IDLE accepts work.
                    hi_q    <= prod_d[63:32];
                    lo_q    <= prod_d[31:0];
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_multu_seq.sv
// ---------------------------------------------------------------------------
// tb_multu_seq -- scoreboard bench for multu_seq. Stimulus pushes the
// hand-computed product of each accepted request into a queue; a monitor
// pops and compares whenever done pulses and flags any unexpected pulse.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_multu_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  ctl   = 6'd0;
    logic [31:0] a     = 32'd0;
    logic [31:0] b     = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_prod = 64'd0;

    multu_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .ctl   (ctl),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_done: got done=1 (hi=0x%08h lo=0x%08h) expected done=0", hi, lo);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("product", {hi, lo}, e);
                last_prod = e;
            end
        end
    end

    task automatic issue(input logic [5:0] c, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        ctl   = c;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            chk_cnt++;
            $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
        end
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'd2,          64'h0000_0001_FFFF_FFFE};
        vecs[1] = '{32'h1234_5678, 32'h10,         64'h0000_0001_2345_6780};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000,  64'h4000_0000_0000_0000};
        vecs[3] = '{32'd0,         32'hDEAD_BEEF,  64'h0000_0000_0000_0000};

        // Reset state while rst_n is low.
        #12;
        check("reset_flags", {62'd0, busy, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);

        // Release reset and request on the very first rising edge: 3*5.
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        ctl   = 6'd25;
        a     = 32'd3;
        b     = 32'd5;
        exp_q.push_back(64'd15);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= 32; i++) begin
            check($sformatf("busy_edge%0d", i), {63'd0, busy}, 64'd1);
            check($sformatf("nodone_edge%0d", i), {63'd0, done}, 64'd0);
            @(negedge clk);
        end
        check("done_edge33", {63'd0, done}, 64'd1);
        check("busy_edge33", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);

        // Largest operands.
        exp_q.push_back(64'hFFFF_FFFE_0000_0001);
        issue(6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("max");

        // 7*6 with a second request mid-operation that must be dropped.
        exp_q.push_back(64'd42);
        issue(6'd25, 32'd7, 32'd6);
        repeat (3) @(negedge clk);
        check("hilo_hold_midop", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        issue(6'd25, 32'd9, 32'd9);
        check("busy_after_ignored_start", {63'd0, busy}, 64'd1);
        wait_done("busy_start");
        repeat (40) @(negedge clk);
        check("lo_after_busy_start", {32'd0, lo}, 64'h2A);

        // Reset in the middle of RUN aborts with no done pulse.
        issue(6'd25, 32'd7, 32'd6);
        repeat (9) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_flags", {62'd0, busy, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        last_prod = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_busy_after", {63'd0, busy}, 64'd0);

        // Signed code: product only in the signed build.
`ifdef MULT_SIGNED_EN
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
        issue(6'd24, 32'hFFFF_FFFD, 32'd5);
        wait_done("signed");
        @(negedge clk);
`else
        issue(6'd24, 32'hFFFF_FFFD, 32'd5);
        check("signed_ignored_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("signed_ignored_hilo", {hi, lo}, last_prod);
`endif

        // Unrecognised code is ignored.
        issue(6'd34, 32'd1, 32'd2);
        check("bad_ctl_busy", {63'd0, busy}, 64'd0);
        check("bad_ctl_done", {63'd0, done}, 64'd0);
        repeat (36) @(negedge clk);
        check("bad_ctl_hilo", {hi, lo}, last_prod);

        // Assorted products.
        foreach (vecs[k]) begin
            exp_q.push_back(vecs[k].p);
            issue(6'd25, vecs[k].x, vecs[k].y);
            wait_done($sformatf("vec%0d", k));
            @(negedge clk);
        end

        // A start presented on the edge that leaves DONE is dropped.
        exp_q.push_back(64'd6);
        issue(6'd25, 32'd2, 32'd3);
        repeat (32) @(negedge clk);
        start = 1'b1;
        ctl   = 6'd25;
        a     = 32'd9;
        b     = 32'd9;
        @(negedge clk);
        start = 1'b0;
        check("done_at_exit", {63'd0, done}, 64'd1);
        check("exit_start_ignored", {63'd0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        check("exit_hilo", {hi, lo}, 64'd6);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Hard stop if the run never reaches its end.
    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected end before 100000ns");
        $fatal(1);
    end

endmodule
